// File: rtl/demokit_mixer.sv
// demokit_mixer: pipelined N-channel combiner (wrap sum, saturating sum, XOR, max)
// with an optional running accumulator that blends successive samples.
// Pipeline: input register -> reduction register -> combine/format/output register.
module demokit_mixer #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                mode,
  input  logic                      acc_en,
  input  logic                      acc_clr,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_ovf
);

  // Reduction width holds the full-precision channel sum; one more bit holds acc + sum.
  localparam int SW = WIDTH + $clog2(CHANNELS);
  localparam int VW = SW + 1;
  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic [1:0] {M_WRAP = 2'b00, M_SAT = 2'b01, M_XOR = 2'b10, M_MAX = 2'b11} mode_e;

  // Valid bit travels alongside the data; bit 2 is the registered out_valid.
  logic [2:0] r_vld_pipe;

  logic [CHANNELS-1:0][WIDTH-1:0] r1_data;
  mode_e                          r1_mode;
  logic                           r1_en, r1_clr;

  logic [SW-1:0] r2_red;
  mode_e         r2_mode;
  logic          r2_en, r2_clr;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_ovf;

  logic [SW-1:0]    w_sum;
  logic [WIDTH-1:0] w_xor, w_max;
  logic [SW-1:0]    w_red;
  logic [WIDTH-1:0] w_a;
  logic [VW-1:0]    w_v;
  logic             w_big;
  logic [WIDTH-1:0] w_fmt;
  logic             w_fmt_ovf;

  assign out_valid = r_vld_pipe[2];
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  // Stage 1: capture the sample and its controls every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_data <= '0;
      r1_mode <= M_WRAP;
      r1_en   <= 1'b0;
      r1_clr  <= 1'b0;
    end else begin
      r1_data <= in_data;
      r1_mode <= mode_e'(mode);
      r1_en   <= acc_en;
      r1_clr  <= acc_clr;
    end
  end

  // Reduce all channels at full precision for the sample's own mode.
  always_comb begin
    w_sum = '0;
    w_xor = '0;
    w_max = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_sum = w_sum + SW'(r1_data[k]);
      w_xor = w_xor ^ r1_data[k];
      if (r1_data[k] > w_max) w_max = r1_data[k];
    end
    case (r1_mode)
      M_XOR:   w_red = SW'(w_xor);
      M_MAX:   w_red = SW'(w_max);
      default: w_red = w_sum;
    endcase
  end

  // Stage 2: hold the reduction with its controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_red  <= '0;
      r2_mode <= M_WRAP;
      r2_en   <= 1'b0;
      r2_clr  <= 1'b0;
    end else begin
      r2_red  <= w_red;
      r2_mode <= r1_mode;
      r2_en   <= r1_en;
      r2_clr  <= r1_clr;
    end
  end

  // Blend with the accumulator (clear wins) and format to WIDTH bits.
  always_comb begin
    w_a = r2_clr ? '0 : r_acc;
    w_v = VW'(r2_red);
    if (r2_en) begin
      case (r2_mode)
        M_XOR:   w_v = VW'(w_a) ^ VW'(r2_red);
        M_MAX:   w_v = (VW'(w_a) > VW'(r2_red)) ? VW'(w_a) : VW'(r2_red);
        default: w_v = VW'(w_a) + VW'(r2_red);
      endcase
    end
    w_big     = w_v > VW'(MAXV);
    w_fmt     = w_v[WIDTH-1:0];
    w_fmt_ovf = 1'b0;
    case (r2_mode)
      M_WRAP:  w_fmt_ovf = w_big;
      M_SAT: begin
        w_fmt     = w_big ? MAXV : w_v[WIDTH-1:0];
        w_fmt_ovf = w_big;
      end
      default: w_fmt_ovf = 1'b0;
    endcase
  end

  // Output stage: publish valid results, hold otherwise; accumulator follows the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], in_valid};
      if (r_vld_pipe[1]) begin
        r_out_data <= w_fmt;
        r_out_ovf  <= w_fmt_ovf;
        r_acc      <= w_fmt;
      end else if (r2_clr) begin
        r_acc <= '0;
      end
    end
  end

endmodule
